// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - AES-128 reverse key schedule walker emitting round keys 10 down to 0
// Loads the final round key, then steps backwards one round per accepted transfer.
module aes_inv_key_schedule #(
  parameter int LAST_ROUND = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key_in,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST = 4'(LAST_ROUND);

  // S-box entry 0 sits in the top byte, so entry x lives at bit offset (255-x)*8 = {~x,000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [31:0]  n0, n1, n2, n3;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub;
  logic [127:0] prev_key;

  assign n0 = key_out[31:0];
  assign n1 = key_out[63:32];
  assign n2 = key_out[95:64];
  assign n3 = key_out[127:96];

  assign w3 = n3 ^ n2;
  assign w2 = n2 ^ n1;
  assign w1 = n1 ^ n0;

  // The previous round's last word is already recovered, so the forward g() can be replayed on it.
  assign rot = {w3[7:0], w3[31:8]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign w0  = n0 ^ {sub[31:8], sub[7:0] ^ rcon(round_out)};

  assign prev_key = {w3, w2, w1, w0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round_out <= 4'd0;
      key_out   <= 128'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= EMIT;
            key_out   <= last_key_in;
            round_out <= LAST;
            key_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        EMIT: begin
          if (key_valid && key_ready) begin
            if (round_out != 4'd0) begin
              key_out   <= prev_key;
              round_out <= round_out - 4'd1;
            end else begin
              state     <= IDLE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
